// File: rtl/rf_write_arbiter.sv
// Writeback arbiter for the register file write port.
// Two in-order source FIFOs (ALU, MEM) drained round-robin into a registered write stage.

module rf_wb_fifo #(
    parameter int DW    = 8,
    parameter int AW    = 5,
    parameter int NREG  = 8,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_valid,
    output logic            push_ready,
    input  logic [AW-1:0]   push_addr,
    input  logic [DW-1:0]   push_data,
    input  logic            pop,
    output logic            head_valid,
    output logic [AW-1:0]   head_addr,
    output logic [DW-1:0]   head_data,
    output logic [NREG-1:0] busy,
    output logic            empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic             push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Per-slot valid bits: the write slot being occupied means full.
    assign push_ready = ~vld_q[wr_q];
    assign push       = push_valid & push_ready;
    assign head_valid = vld_q[rd_q];
    assign head_addr  = addr_q[rd_q];
    assign head_data  = data_q[rd_q];
    assign empty      = ~|vld_q;

    // Pop clears the head slot, push fills the tail slot; push applied last.
    always_comb begin
        vld_d  = vld_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        addr_d = addr_q;
        data_d = data_q;
        if (pop) begin
            vld_d[rd_q] = 1'b0;
            rd_d        = ptr_inc(rd_q);
        end
        if (push) begin
            vld_d[wr_q]  = 1'b1;
            addr_d[wr_q] = push_addr;
            data_d[wr_q] = push_data;
            wr_d         = ptr_inc(wr_q);
        end
    end

    // Queued destination registers; register 0 and out-of-range never mark busy.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int r = 1; r < NREG; r++) begin
                if (vld_q[i] && (addr_q[i] == AW'(r))) begin
                    busy[r] = 1'b1;
                end
            end
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            addr_q <= '{default: '0};
            data_q <= '{default: '0};
        end else begin
            vld_q  <= vld_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

endmodule

module rf_write_arbiter #(
    parameter int DW    = 8,
    parameter int AW    = 5,
    parameter int NREG  = 8,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_addr,
    input  logic [DW-1:0]   alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [DW-1:0]   rf_wd,
    output logic [NREG-1:0] busy_mask,
    output logic            idle
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    src_e             rr_last_q, rr_last_d;
    logic             rf_we_q, rf_we_d;
    logic [AW-1:0]    rf_wa_q, rf_wa_d;
    logic [DW-1:0]    rf_wd_q, rf_wd_d;

    logic             alu_hv, mem_hv;
    logic [AW-1:0]    alu_ha, mem_ha;
    logic [DW-1:0]    alu_hd, mem_hd;
    logic [NREG-1:0]  alu_busy, mem_busy, out_busy;
    logic             alu_empty, mem_empty;
    logic             gnt_alu, gnt_mem;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREG);
    endfunction

    rf_wb_fifo #(
        .DW(DW), .AW(AW), .NREG(NREG), .DEPTH(DEPTH)
    ) u_alu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (alu_valid),
        .push_ready (alu_ready),
        .push_addr  (alu_addr),
        .push_data  (alu_data),
        .pop        (gnt_alu),
        .head_valid (alu_hv),
        .head_addr  (alu_ha),
        .head_data  (alu_hd),
        .busy       (alu_busy),
        .empty      (alu_empty)
    );

    rf_wb_fifo #(
        .DW(DW), .AW(AW), .NREG(NREG), .DEPTH(DEPTH)
    ) u_mem_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (mem_valid),
        .push_ready (mem_ready),
        .push_addr  (mem_addr),
        .push_data  (mem_data),
        .pop        (gnt_mem),
        .head_valid (mem_hv),
        .head_addr  (mem_ha),
        .head_data  (mem_hd),
        .busy       (mem_busy),
        .empty      (mem_empty)
    );

    // Round-robin grant: on a tie the source not granted last wins.
    always_comb begin
        gnt_alu = alu_hv & (~mem_hv | (rr_last_q == SRC_MEM));
        gnt_mem = mem_hv & ~gnt_alu;
    end

    // Output stage load: invalid destinations consume the slot with we=0.
    always_comb begin
        rr_last_d = rr_last_q;
        rf_we_d   = 1'b0;
        rf_wa_d   = rf_wa_q;
        rf_wd_d   = rf_wd_q;
        if (gnt_alu) begin
            rr_last_d = SRC_ALU;
            rf_we_d   = addr_ok(alu_ha);
            rf_wa_d   = alu_ha;
            rf_wd_d   = alu_hd;
        end else if (gnt_mem) begin
            rr_last_d = SRC_MEM;
            rf_we_d   = addr_ok(mem_ha);
            rf_wa_d   = mem_ha;
            rf_wd_d   = mem_hd;
        end
    end

    // Register on the output stage counts as pending until it leaves.
    always_comb begin
        out_busy = '0;
        for (int r = 1; r < NREG; r++) begin
            if (rf_we_q && (rf_wa_q == AW'(r))) begin
                out_busy[r] = 1'b1;
            end
        end
    end

    assign busy_mask = alu_busy | mem_busy | out_busy;
    assign idle      = alu_empty & mem_empty & ~rf_we_q;
    assign rf_we     = rf_we_q;
    assign rf_wa     = rf_wa_q;
    assign rf_wd     = rf_wd_q;

    // Arbiter pointer and write-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= SRC_MEM;
            rf_we_q   <= 1'b0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            rf_we_q   <= rf_we_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter.
// Expected writes are queued with the stimulus; a monitor checks every rf_we cycle.

module tb_rf_write_arbiter;

    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk;
    logic       rst;
    logic       alu_valid, alu_ready;
    logic [4:0] alu_addr;
    logic [7:0] alu_data;
    logic       mem_valid, mem_ready;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       rf_we;
    logic [4:0] rf_wa;
    logic [7:0] rf_wd;
    logic [7:0] busy_mask;
    logic       idle;

    int  checks   = 0;
    int  failures = 0;
    wr_t exp_q[$];

    rf_write_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .busy_mask (busy_mask),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every issued write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: got wa=%0d wd=%h required none",
                         rf_wa, rf_wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (rf_wa !== e.a || rf_wd !== e.d) begin
                    failures++;
                    $display("FAIL wr_order: got wa=%0d wd=%h required wa=%0d wd=%h",
                             rf_wa, rf_wd, e.a, e.d);
                end
            end
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic send_alu(input logic [4:0] a, input logic [7:0] d);
        int n = 0;
        alu_valid = 1'b1;
        alu_addr  = a;
        alu_data  = d;
        while (!alu_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("alu_ready_timeout", 0, 1);
        @(negedge clk);
        alu_valid = 1'b0;
    endtask

    task automatic send_mem(input logic [4:0] a, input logic [7:0] d);
        int n = 0;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_data  = d;
        while (!mem_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("mem_ready_timeout", 0, 1);
        @(negedge clk);
        mem_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        mem_addr  = '0;
        mem_data  = '0;
        repeat (2) @(negedge clk);

        chk("rst_we", rf_we, 0);
        chk("rst_wa", rf_wa, 0);
        chk("rst_wd", rf_wd, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_idle", idle, 1);
        chk("rst_ready", {alu_ready, mem_ready}, 2'b11);
        rst = 1'b0;

        // Single ALU write.
        expect_wr(5'd3, 8'h5A);
        alu_valid = 1'b1;
        alu_addr  = 5'd3;
        alu_data  = 8'h5A;
        @(negedge clk);
        alu_valid = 1'b0;
        chk("s1_c1_busy", busy_mask, 8'h08);
        chk("s1_c1_we", rf_we, 0);
        chk("s1_c1_idle", idle, 0);
        @(negedge clk);
        chk("s1_c2_we_wa_wd", {rf_we, rf_wa, rf_wd}, {1'b1, 5'd3, 8'h5A});
        chk("s1_c2_busy", busy_mask, 8'h08);
        @(negedge clk);
        chk("s1_c3_idle", idle, 1);
        chk("s1_c3_busy", busy_mask, 0);
        wait_drain("s1_drain");

        // Contention: grants alternate ALU, MEM, ALU, MEM.
        do_reset();
        expect_wr(5'd1, 8'h11);
        expect_wr(5'd2, 8'h22);
        expect_wr(5'd4, 8'h44);
        expect_wr(5'd5, 8'h55);
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 8'h11;
        mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 8'h22;
        @(negedge clk);
        alu_addr = 5'd4; alu_data = 8'h44;
        mem_addr = 5'd5; mem_data = 8'h55;
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("s2_c2", {rf_we, rf_wa}, {1'b1, 5'd1});
        @(negedge clk);
        chk("s2_c3", {rf_we, rf_wa}, {1'b1, 5'd2});
        @(negedge clk);
        chk("s2_c4", {rf_we, rf_wa}, {1'b1, 5'd4});
        @(negedge clk);
        chk("s2_c5", {rf_we, rf_wa}, {1'b1, 5'd5});
        wait_drain("s2_drain");

        // Backpressure: MEM holds 3 entries while ALU streams 5.
        do_reset();
        expect_wr(5'd1, 8'hA0);
        expect_wr(5'd6, 8'hC0);
        expect_wr(5'd2, 8'hA1);
        expect_wr(5'd7, 8'hC1);
        expect_wr(5'd3, 8'hA2);
        expect_wr(5'd6, 8'hC2);
        expect_wr(5'd4, 8'hA3);
        expect_wr(5'd5, 8'hA4);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send_alu(5'(i + 1), 8'(8'hA0 + i));
                    if (i < 4) alu_valid = 1'b1;
                end
            end
            begin
                send_mem(5'd6, 8'hC0);
                send_mem(5'd7, 8'hC1);
                send_mem(5'd6, 8'hC2);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                chk("s3_mem_ready_full", mem_ready, 0);
                @(negedge clk);
                chk("s3_mem_ready_free", mem_ready, 1);
            end
        join
        wait_drain("s3_drain");

        // Invalid addresses consume slots without writing.
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 8'hFF;
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 8'h77;
        chk("s4_c1_busy", busy_mask, 0);
        @(negedge clk);
        mem_valid = 1'b0;
        chk("s4_c2_out", {rf_we, rf_wa, rf_wd}, {1'b0, 5'd0, 8'hFF});
        chk("s4_c2_busy", busy_mask, 0);
        @(negedge clk);
        chk("s4_c3_out", {rf_we, rf_wa, rf_wd}, {1'b0, 5'd9, 8'h77});
        chk("s4_c3_busy", busy_mask, 0);
        chk("s4_c3_idle", idle, 1);

        // Same-register WAW from reset: ALU first, then MEM.
        do_reset();
        expect_wr(5'd6, 8'hB0);
        expect_wr(5'd6, 8'hA0);
        alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 8'hB0;
        mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 8'hA0;
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("s5_c1_busy", busy_mask, 8'h40);
        @(negedge clk);
        chk("s5_c2_wd", {rf_we, rf_wd}, {1'b1, 8'hB0});
        chk("s5_c2_busy", busy_mask, 8'h40);
        @(negedge clk);
        chk("s5_c3_wd", {rf_we, rf_wd}, {1'b1, 8'hA0});
        chk("s5_c3_busy", busy_mask, 8'h40);
        @(negedge clk);
        chk("s5_c4_busy", busy_mask, 0);
        chk("s5_c4_idle", idle, 1);
        wait_drain("s5_drain");

        // Reset with queued writes: only the write already on the port appears.
        do_reset();
        expect_wr(5'd1, 8'h11);
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 8'h11;
        mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 8'h22;
        @(negedge clk);
        alu_addr = 5'd3; alu_data = 8'h33;
        mem_addr = 5'd4; mem_data = 8'h44;
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("s6_pre_busy", busy_mask, 8'h1E);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s6_we", rf_we, 0);
        chk("s6_busy", busy_mask, 0);
        chk("s6_ready", {alu_ready, mem_ready}, 2'b11);
        chk("s6_idle", idle, 1);
        chk("s6_sb_empty", exp_q.size(), 0);
        repeat (6) @(negedge clk);
        chk("s6_end_idle", idle, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
